// File: rtl/fft_peak_picker.sv
// rtl/fft_peak_picker.sv - streaming FFT peak picker feeding freq_estimator
// Squares and sums each bin in a three-register pipeline and resolves the frame peak one edge later.
module fft_peak_picker #(
    parameter int unsigned MIN_BIN = 2,
    parameter int unsigned MAX_BIN = 511,
    parameter logic [31:0] MIN_MAG = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic [9:0]  s_index,
    input  logic [15:0] s_re,
    input  logic [15:0] s_im,
    input  logic [31:0] s_phase,
    input  logic        est_done,
    output logic        start,
    output logic [9:0]  max_index,
    output logic [31:0] max_phase,
    output logic [31:0] max_mag,
    output logic        busy,
    output logic        no_peak,
    output logic        overrun
);
    localparam logic [9:0] LP_MIN_BIN = 10'(MIN_BIN);
    localparam logic [9:0] LP_MAX_BIN = 10'(MAX_BIN);

    logic signed [31:0] w_re_sq;
    logic signed [31:0] w_im_sq;
    logic               w_in_band;
    logic               w_qual;
    logic               w_found_nx;
    logic [31:0]        w_best_mag_nx;
    logic [9:0]         w_best_index_nx;
    logic [31:0]        w_best_phase_nx;
    logic               w_frame_end;
    logic               w_busy_eff;

    logic        r_s1_valid, r_s1_last;
    logic [9:0]  r_s1_index;
    logic [31:0] r_s1_phase, r_s1_re2, r_s1_im2;
    logic        r_s2_valid, r_s2_last;
    logic [9:0]  r_s2_index;
    logic [31:0] r_s2_phase, r_s2_mag;
    logic        r_s3_valid, r_s3_last;
    logic [9:0]  r_s3_index;
    logic [31:0] r_s3_phase, r_s3_mag;
    logic [31:0] r_best_mag, r_best_phase;
    logic [9:0]  r_best_index;
    logic        r_found;
    logic        r_start, r_busy, r_no_peak, r_overrun;
    logic [9:0]  r_max_index;
    logic [31:0] r_max_phase, r_max_mag;

    // Squares are non-negative and at most 2^30, so the sum never reaches bit 32.
    assign w_re_sq = 32'($signed(s_re)) * 32'($signed(s_re));
    assign w_im_sq = 32'($signed(s_im)) * 32'($signed(s_im));

    assign w_in_band       = (r_s3_index >= LP_MIN_BIN) && (r_s3_index <= LP_MAX_BIN);
    assign w_qual          = r_s3_valid && w_in_band && (r_s3_mag > MIN_MAG) && (r_s3_mag > r_best_mag);
    assign w_found_nx      = r_found || w_qual;
    assign w_best_mag_nx   = w_qual ? r_s3_mag   : r_best_mag;
    assign w_best_index_nx = w_qual ? r_s3_index : r_best_index;
    assign w_best_phase_nx = w_qual ? r_s3_phase : r_best_phase;
    assign w_frame_end     = r_s3_valid && r_s3_last;
    // A done arriving on the resolving edge frees the estimator for this frame.
    assign w_busy_eff      = r_busy && !est_done;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0; r_s1_last <= 1'b0; r_s1_index <= '0;
            r_s1_phase <= '0;   r_s1_re2 <= '0;   r_s1_im2 <= '0;
            r_s2_valid <= 1'b0; r_s2_last <= 1'b0; r_s2_index <= '0;
            r_s2_phase <= '0;   r_s2_mag <= '0;
            r_s3_valid <= 1'b0; r_s3_last <= 1'b0; r_s3_index <= '0;
            r_s3_phase <= '0;   r_s3_mag <= '0;
        end else begin
            r_s1_valid <= s_valid;
            r_s1_last  <= s_valid && s_last;
            r_s1_index <= s_index;
            r_s1_phase <= s_phase;
            r_s1_re2   <= w_re_sq;
            r_s1_im2   <= w_im_sq;
            r_s2_valid <= r_s1_valid;
            r_s2_last  <= r_s1_last;
            r_s2_index <= r_s1_index;
            r_s2_phase <= r_s1_phase;
            r_s2_mag   <= r_s1_re2 + r_s1_im2;
            r_s3_valid <= r_s2_valid;
            r_s3_last  <= r_s2_last;
            r_s3_index <= r_s2_index;
            r_s3_phase <= r_s2_phase;
            r_s3_mag   <= r_s2_mag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_best_mag   <= '0;
            r_best_index <= '0;
            r_best_phase <= '0;
            r_found      <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_no_peak    <= 1'b0;
            r_overrun    <= 1'b0;
            r_max_index  <= '0;
            r_max_phase  <= '0;
            r_max_mag    <= '0;
        end else begin
            r_start   <= 1'b0;
            r_no_peak <= 1'b0;
            r_overrun <= 1'b0;
            r_busy    <= w_busy_eff;
            if (w_frame_end) begin
                r_best_mag   <= '0;
                r_best_index <= '0;
                r_best_phase <= '0;
                r_found      <= 1'b0;
                if (w_found_nx && !w_busy_eff) begin
                    r_max_index <= w_best_index_nx;
                    r_max_phase <= w_best_phase_nx;
                    r_max_mag   <= w_best_mag_nx;
                    r_start     <= 1'b1;
                    r_busy      <= 1'b1;
                end else if (w_found_nx) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_no_peak <= 1'b1;
                end
            end else begin
                r_best_mag   <= w_best_mag_nx;
                r_best_index <= w_best_index_nx;
                r_best_phase <= w_best_phase_nx;
                r_found      <= w_found_nx;
            end
        end
    end

    assign start     = r_start;
    assign busy      = r_busy;
    assign no_peak   = r_no_peak;
    assign overrun   = r_overrun;
    assign max_index = r_max_index;
    assign max_phase = r_max_phase;
    assign max_mag   = r_max_mag;
endmodule

// File: tb/tb_fft_peak_picker.sv
// tb/tb_fft_peak_picker.sv - self-checking bench for fft_peak_picker
// Frame-level reference model predicts every output each cycle; directed frames pin the model.
module tb_fft_peak_picker;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic [9:0]  s_index = '0;
    logic [15:0] s_re = '0;
    logic [15:0] s_im = '0;
    logic [31:0] s_phase = '0;
    logic        est_done = 1'b0;
    logic        start, busy, no_peak, overrun;
    logic [9:0]  max_index;
    logic [31:0] max_phase, max_mag;

    fft_peak_picker dut (
        .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_last(s_last),
        .s_index(s_index), .s_re(s_re), .s_im(s_im), .s_phase(s_phase),
        .est_done(est_done), .start(start), .max_index(max_index),
        .max_phase(max_phase), .max_mag(max_mag), .busy(busy),
        .no_peak(no_peak), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        longint      due;
        bit          found;
        logic [9:0]  idx;
        logic [31:0] ph;
        logic [31:0] mag;
    } res_t;

    res_t        pend_q[$];
    res_t        m_res;
    logic [9:0]  fb_idx[$];
    longint      fb_mag[$];
    logic [31:0] fb_ph[$];
    logic [9:0]  start_log[$];
    longint      cyc = 0;
    bit          m_busy = 0, m_eff;
    bit          exp_start = 0, exp_no_peak = 0, exp_overrun = 0;
    logic [9:0]  exp_idx = '0;
    logic [31:0] exp_ph = '0, exp_mag = '0;

    function automatic res_t frame_peak(input longint due);
        res_t   r;
        longint best;
        r.due = due; r.found = 0; r.idx = '0; r.ph = '0; r.mag = '0;
        best = 0;
        for (int i = 0; i < fb_idx.size(); i++) begin
            if (fb_idx[i] >= 2 && fb_idx[i] <= 511 && fb_mag[i] > 64'h1000 && fb_mag[i] > best) begin
                best    = fb_mag[i];
                r.found = 1;
                r.idx   = fb_idx[i];
                r.ph    = fb_ph[i];
                r.mag   = 32'(fb_mag[i]);
            end
        end
        return r;
    endfunction

    // Reference model plus the per-cycle compare.
    always @(posedge clk) begin
        longint re_v, im_v;
        cyc++;
        exp_start = 0; exp_no_peak = 0; exp_overrun = 0;
        if (!reset_n) begin
            fb_idx.delete(); fb_mag.delete(); fb_ph.delete(); pend_q.delete();
            m_busy = 0; exp_idx = '0; exp_ph = '0; exp_mag = '0;
        end else begin
            m_eff  = m_busy && !est_done;
            m_busy = m_eff;
            if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
                m_res = pend_q.pop_front();
                if (m_res.found && !m_eff) begin
                    exp_start = 1; m_busy = 1;
                    exp_idx = m_res.idx; exp_ph = m_res.ph; exp_mag = m_res.mag;
                end else if (m_res.found) begin
                    exp_overrun = 1;
                end else begin
                    exp_no_peak = 1;
                end
            end
            if (s_valid) begin
                re_v = longint'($signed(s_re));
                im_v = longint'($signed(s_im));
                fb_idx.push_back(s_index);
                fb_mag.push_back(re_v * re_v + im_v * im_v);
                fb_ph.push_back(s_phase);
                if (s_last) begin
                    pend_q.push_back(frame_peak(cyc + 3));
                    fb_idx.delete(); fb_mag.delete(); fb_ph.delete();
                end
            end
        end
        #1;
        check("start", 32'(start), 32'(exp_start));
        check("no_peak", 32'(no_peak), 32'(exp_no_peak));
        check("overrun", 32'(overrun), 32'(exp_overrun));
        check("busy", 32'(busy), 32'(m_busy));
        check("max_index", 32'(max_index), 32'(exp_idx));
        check("max_phase", max_phase, exp_ph);
        check("max_mag", max_mag, exp_mag);
        if (start) start_log.push_back(max_index);
    end

    logic [15:0] f_re[1024];
    logic [15:0] f_im[1024];
    logic [31:0] f_ph[1024];
    bit          rnd_done = 0;

    task automatic clear_frame();
        for (int i = 0; i < 1024; i++) begin
            f_re[i] = '0; f_im[i] = '0; f_ph[i] = 32'(i) * 32'h0001_0003;
        end
    endtask

    task automatic send_frame(input int n, input int first, input bit gaps, input bit with_last);
        for (int i = 0; i < n; i++) begin
            logic [9:0] ix;
            ix = 10'(first + i);
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    @(negedge clk); s_valid = 0; s_last = 0;
                end
            end
            @(negedge clk);
            s_valid = 1; s_last = with_last && (i == n - 1);
            s_index = ix; s_re = f_re[ix]; s_im = f_im[ix]; s_phase = f_ph[ix];
        end
    endtask

    task automatic idle();
        @(negedge clk); s_valid = 0; s_last = 0;
    endtask

    task automatic pulse_done();
        @(negedge clk); est_done = 1;
        @(negedge clk); est_done = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1;
        check("reset_start", 32'(start), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_max_index", 32'(max_index), 32'h0);

        // Single peak at bin 150 with literal latency and values.
        clear_frame(); f_re[150] = 16'h4000; f_ph[150] = 32'h0010_0000;
        send_frame(512, 0, 0, 1); idle();
        repeat (2) @(negedge clk);
        check("lit_not_early", 32'(start), 32'h0);
        @(negedge clk);
        check("lit_start", 32'(start), 32'h1);
        check("lit_index", 32'(max_index), 32'd150);
        check("lit_phase", max_phase, 32'h0010_0000);
        check("lit_mag", max_mag, 32'h1000_0000);
        check("lit_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("lit_start_one_cycle", 32'(start), 32'h0);
        pulse_done();
        check("lit_busy_cleared", 32'(busy), 32'h0);

        // Tie keeps the earlier bin; bin 1 is below the band.
        clear_frame(); f_re[100] = 16'h2000; f_re[200] = 16'h2000; f_re[1] = 16'h7FFF;
        send_frame(512, 0, 0, 1); idle();
        repeat (3) @(negedge clk);
        check("tie_start", 32'(start), 32'h1);
        check("tie_index", 32'(max_index), 32'd100);
        check("tie_mag", max_mag, 32'h0400_0000);
        pulse_done();

        // Every bin below threshold.
        clear_frame();
        for (int i = 0; i < 1024; i++) begin f_re[i] = 16'h0020; f_im[i] = 16'h0020; end
        send_frame(512, 0, 0, 1); idle();
        repeat (3) @(negedge clk);
        check("nopeak_pulse", 32'(no_peak), 32'h1);
        check("nopeak_no_start", 32'(start), 32'h0);
        check("nopeak_retain", 32'(max_index), 32'd100);

        // Overrun while busy, then done coincident with resolution.
        clear_frame(); f_re[150] = 16'h4000;
        send_frame(512, 0, 0, 1); idle();
        repeat (4) @(negedge clk);
        clear_frame(); f_re[300] = 16'h3000;
        send_frame(512, 0, 0, 1); idle();
        repeat (3) @(negedge clk);
        check("ovr_pulse", 32'(overrun), 32'h1);
        check("ovr_no_start", 32'(start), 32'h0);
        check("ovr_retain", 32'(max_index), 32'd150);
        clear_frame(); f_re[250] = 16'h1000;
        send_frame(512, 0, 0, 1); idle();
        repeat (2) @(negedge clk);
        est_done = 1;
        @(negedge clk); est_done = 0;
        check("coinc_start", 32'(start), 32'h1);
        check("coinc_no_overrun", 32'(overrun), 32'h0);
        check("coinc_index", 32'(max_index), 32'd250);
        pulse_done();

        // Back-to-back frames; the stronger first peak must not leak.
        start_log.delete();
        fork
            begin
                clear_frame(); f_re[150] = 16'h4000;
                send_frame(512, 0, 0, 1);
                clear_frame(); f_re[300] = 16'h1000;
                send_frame(512, 0, 0, 1);
                idle();
            end
            begin
                repeat (600) @(negedge clk);
                est_done = 1;
                @(negedge clk); est_done = 0;
            end
        join
        repeat (4) @(negedge clk);
        check("b2b_count", 32'(start_log.size()), 32'd2);
        if (start_log.size() == 2) begin
            check("b2b_first", 32'(start_log[0]), 32'd150);
            check("b2b_second", 32'(start_log[1]), 32'd300);
        end

        // Reset mid-frame discards the partial frame.
        clear_frame(); f_re[400] = 16'h7000;
        send_frame(421, 0, 0, 0);
        @(negedge clk); s_valid = 0; reset_n = 0;
        #1;
        check("rst_start", 32'(start), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_index", 32'(max_index), 32'h0);
        check("rst_phase", max_phase, 32'h0);
        check("rst_mag", max_mag, 32'h0);
        @(negedge clk); reset_n = 1;
        clear_frame(); f_re[77] = 16'h0100;
        send_frame(512, 0, 0, 1); idle();
        repeat (3) @(negedge clk);
        check("post_rst_start", 32'(start), 32'h1);
        check("post_rst_index", 32'(max_index), 32'd77);
        check("post_rst_mag", max_mag, 32'h0001_0000);
        pulse_done();

        // Random frames with gaps and random done pulses.
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    int len, first;
                    len = $urandom_range(1, 600);
                    first = $urandom_range(0, 1023);
                    for (int i = 0; i < len; i++) begin
                        logic [9:0] ix;
                        ix = 10'(first + i);
                        f_ph[ix] = $urandom;
                        case ($urandom_range(0, 5))
                            0: begin f_re[ix] = '0; f_im[ix] = '0; end
                            1, 2: begin
                                f_re[ix] = 16'($signed($urandom_range(0, 160)) - 80);
                                f_im[ix] = 16'($signed($urandom_range(0, 160)) - 80);
                            end
                            3: begin f_re[ix] = 16'h8000; f_im[ix] = 16'h8000; end
                            default: begin f_re[ix] = 16'($urandom); f_im[ix] = 16'($urandom); end
                        endcase
                    end
                    send_frame(len, first, 1, 1);
                    if ($urandom_range(0, 1) == 0) idle();
                end
                idle();
                repeat (10) @(negedge clk);
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    est_done = ($urandom_range(0, 15) == 0);
                end
                est_done = 0;
            end
        join
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
